// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port data memory. The arbiter takes the slave view; the
// requesters and the memory together take the master view.
interface dmem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    // pipeline MEM/WB load/store path
    logic          p_req;
    logic          p_we;
    logic          p_half;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_valid;
    logic          p_stall;

    // debug display read port
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    // data memory side
    logic          mem_en;
    logic          mem_we;
    logic          mem_half;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_half, p_addr, p_wdata,
        output p_rdata, p_valid, p_stall,
        input  d_req, d_addr,
        output d_rdata, d_valid,
        output mem_en, mem_we, mem_half, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_half, p_addr, p_wdata,
        input  p_rdata, p_valid, p_stall,
        output d_req, d_addr,
        input  d_rdata, d_valid,
        input  mem_en, mem_we, mem_half, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the pipeline (priority) and
// the debug display reader. A starvation counter forces one debug slot
// after MAX_WAIT contended cycles; the pipeline is stalled in that slot.
module dmem_port_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8     // legal range 1..255
) (
    input  logic                clk,
    input  logic                in_RST,
    dmem_port_arbiter_if.slave  bus
);
    localparam int          CW      = 8;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic       {ST_PRI, ST_FORCE}             arb_state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_P, GNT_D}       grant_e;
    typedef enum logic [1:0] {RESP_NONE, RESP_P, RESP_D}    resp_e;

    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    arb_state_e    state;
    grant_e        grant;
    resp_e         resp, resp_nxt;
    logic          p_stall;
    logic [DW-1:0] p_hold, d_hold;

    // The arbitration state is fully captured by the starvation counter.
    assign state = (wait_cnt == WAIT_MAX) ? ST_FORCE : ST_PRI;

    // Grant selection; reset gates every grant so mem_* and p_stall drop at once.
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant   = GNT_NONE;
        p_stall = 1'b0;
        if (in_RST) begin
            if (state == ST_FORCE && bus.d_req) begin
                grant   = GNT_D;
                p_stall = bus.p_req;
            end else if (bus.p_req) begin
                grant = GNT_P;
            end else if (bus.d_req) begin
                grant = GNT_D;
            end
        end
    end

    // Memory drive follows the winning requester; idle cycles drive zeros.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_half  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (grant)
            GNT_P: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.p_we;
                bus.mem_half  = bus.p_half;
                bus.mem_addr  = bus.p_addr;
                bus.mem_wdata = bus.p_wdata;
            end
            GNT_D: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.d_addr;
            end
            default: ;
        endcase
    end

    // Next counter value and response type derived from this cycle's grant.
    always_comb begin
        wait_cnt_nxt = '0;
        resp_nxt     = RESP_NONE;
        if (grant == GNT_D) begin
            wait_cnt_nxt = '0;
        end else if (bus.d_req && grant == GNT_P) begin
            wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        end
        if (grant == GNT_P && !bus.p_we) begin
            resp_nxt = RESP_P;
        end else if (grant == GNT_D) begin
            resp_nxt = RESP_D;
        end
    end

    // Counter and response registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            wait_cnt <= '0;
            resp     <= RESP_NONE;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            resp     <= resp_nxt;
        end
    end

    // Hold the last returned word of each port until its next response.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            p_hold <= '0;
            d_hold <= '0;
        end else begin
            if (resp == RESP_P) p_hold <= bus.mem_rdata;
            if (resp == RESP_D) d_hold <= bus.mem_rdata;
        end
    end

    assign bus.p_stall = p_stall;
    assign bus.p_valid = (resp == RESP_P);
    assign bus.d_valid = (resp == RESP_D);
    assign bus.p_rdata = (resp == RESP_P) ? bus.mem_rdata : p_hold;
    assign bus.d_rdata = (resp == RESP_D) ? bus.mem_rdata : d_hold;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, hand sequences for the
// starvation/reset corners, and a randomized run against a reference model.
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic in_RST;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .in_RST(in_RST), .bus(bus.slave));
    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(1)) u_dut1 (
        .clk(clk), .in_RST(in_RST), .bus(bus1.slave));

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hA500_0000 | DW'(i));
    endfunction

    // Small behavioural data memories, one per arbiter, 1-cycle read latency.
    logic [DW-1:0] ram  [64];
    logic [DW-1:0] ram1 [64];
    always @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[5:0]];
        end
    end
    always @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            for (int k = 0; k < 64; k++) ram1[k] <= init_word(k);
            bus1.mem_rdata <= '0;
        end else if (bus1.mem_en) begin
            if (bus1.mem_we) ram1[bus1.mem_addr[5:0]] <= bus1.mem_wdata;
            else             bus1.mem_rdata <= ram1[bus1.mem_addr[5:0]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pr, input logic pw, input logic ph,
                         input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic dr, input logic [AW-1:0] da);
        bus.p_req = pr; bus.p_we = pw; bus.p_half = ph;
        bus.p_addr = pa; bus.p_wdata = pd;
        bus.d_req = dr; bus.d_addr = da;
    endtask

    typedef struct {
        logic          p_req, p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic          d_req;
        logic [AW-1:0] d_addr;
        logic          e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_stall, e_pv;
        logic [DW-1:0] e_prd;
        logic          e_dv;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t vecs [9];

    // reference-model state for the randomized run
    int            denied;
    logic [DW-1:0] model_mem [64];
    logic          m_pv, m_dv;
    logic [DW-1:0] m_prd, m_drd;

    initial begin
        //            p_req we addr    wdata         d_req d_addr | en we addr    wdata         stall pv prd           dv drd
        vecs[0] = '{1'b0,1'b0,12'h000,32'h0,       1'b1,12'h010, 1'b1,1'b0,12'h010,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h0};
        vecs[1] = '{1'b0,1'b0,12'h000,32'h0,       1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'hDEADBEEF};
        vecs[2] = '{1'b0,1'b0,12'h000,32'h0,       1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'hDEADBEEF};
        vecs[3] = '{1'b1,1'b1,12'h004,32'h12345678,1'b0,12'h000, 1'b1,1'b1,12'h004,32'h12345678,1'b0,1'b0,32'h0,        1'b0,32'hDEADBEEF};
        vecs[4] = '{1'b1,1'b0,12'h004,32'h0,       1'b0,12'h000, 1'b1,1'b0,12'h004,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'hDEADBEEF};
        vecs[5] = '{1'b0,1'b0,12'h000,32'h0,       1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,       1'b0,1'b1,32'h12345678, 1'b0,32'hDEADBEEF};
        vecs[6] = '{1'b1,1'b0,12'h010,32'h0,       1'b1,12'h004, 1'b1,1'b0,12'h010,32'h0,       1'b0,1'b0,32'h12345678, 1'b0,32'hDEADBEEF};
        vecs[7] = '{1'b0,1'b0,12'h000,32'h0,       1'b1,12'h004, 1'b1,1'b0,12'h004,32'h0,       1'b0,1'b1,32'hDEADBEEF, 1'b0,32'hDEADBEEF};
        vecs[8] = '{1'b0,1'b0,12'h000,32'h0,       1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,       1'b0,1'b0,32'hDEADBEEF, 1'b1,32'h12345678};

        // reset with both requests raised: every output must stay 0
        in_RST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 12'h010, '0, 1'b1, 12'h010);
        bus1.p_req = 1'b0; bus1.p_we = 1'b0; bus1.p_half = 1'b0;
        bus1.p_addr = '0; bus1.p_wdata = '0; bus1.d_req = 1'b0; bus1.d_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst mem_en",  bus.mem_en,  1'b0);
        check("rst p_stall", bus.p_stall, 1'b0);
        check("rst p_valid", bus.p_valid, 1'b0);
        check("rst d_valid", bus.d_valid, 1'b0);
        check("rst p_rdata", bus.p_rdata, 32'h0);
        check("rst d_rdata", bus.d_rdata, 32'h0);
        check("rst mem_addr", bus.mem_addr, 12'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        in_RST = 1'b1;

        // table-driven debug read, store/load, contention
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].p_req, vecs[i].p_we, 1'b0, vecs[i].p_addr, vecs[i].p_wdata,
                  vecs[i].d_req, vecs[i].d_addr);
            #1;
            check($sformatf("v%0d mem_en", i), bus.mem_en, vecs[i].e_en);
            if (vecs[i].e_en) begin
                check($sformatf("v%0d mem_we", i),    bus.mem_we,    vecs[i].e_we);
                check($sformatf("v%0d mem_addr", i),  bus.mem_addr,  vecs[i].e_addr);
                check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
            end
            check($sformatf("v%0d p_stall", i), bus.p_stall, vecs[i].e_stall);
            check($sformatf("v%0d p_valid", i), bus.p_valid, vecs[i].e_pv);
            check($sformatf("v%0d p_rdata", i), bus.p_rdata, vecs[i].e_prd);
            check($sformatf("v%0d d_valid", i), bus.d_valid, vecs[i].e_dv);
            check($sformatf("v%0d d_rdata", i), bus.d_rdata, vecs[i].e_drd);
        end

        // full contention: one forced debug slot every MW+1 cycles
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, AW'(i), '0, 1'b1, 12'h010);
            #1;
            check($sformatf("cont%0d p_stall", i), bus.p_stall, (i % 9) == 8);
            check($sformatf("cont%0d mem_addr", i), bus.mem_addr, ((i % 9) == 8) ? 12'h010 : AW'(i));
            check($sformatf("cont%0d p_valid", i), bus.p_valid, (i > 0) && ((i - 1) % 9 != 8));
            check($sformatf("cont%0d d_valid", i), bus.d_valid, (i > 0) && ((i - 1) % 9 == 8));
            if ((i > 0) && ((i - 1) % 9 == 8))
                check($sformatf("cont%0d d_rdata", i), bus.d_rdata, 32'hDEADBEEF);
        end

        // counter at MW, then d_req drops before the forced slot
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 12'h001, '0, 1'b1, 12'h010);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 12'h002, '0, 1'b0, 12'h010);
        #1;
        check("drop p_stall",  bus.p_stall,  1'b0);
        check("drop mem_addr", bus.mem_addr, 12'h002);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 12'h003, '0, 1'b1, 12'h010);
        #1;
        check("cleared p_stall",  bus.p_stall,  1'b0);
        check("cleared mem_addr", bus.mem_addr, 12'h003);
        for (int i = 0; i < MW - 1; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 12'h001, '0, 1'b1, 12'h010);
            #1;
            check($sformatf("refill%0d p_stall", i), bus.p_stall, 1'b0);
        end

        // store arriving in the forced slot is held one cycle
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 12'h020, 32'hCAFE0001, 1'b1, 12'h010);
        #1;
        check("fstore p_stall",  bus.p_stall,  1'b1);
        check("fstore mem_we",   bus.mem_we,   1'b0);
        check("fstore mem_addr", bus.mem_addr, 12'h010);
        @(negedge clk);
        #1;
        check("store p_stall",   bus.p_stall,   1'b0);
        check("store mem_we",    bus.mem_we,    1'b1);
        check("store mem_addr",  bus.mem_addr,  12'h020);
        check("store mem_wdata", bus.mem_wdata, 32'hCAFE0001);
        check("store d_valid",   bus.d_valid,   1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 12'h020, '0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        #1;
        check("store rd p_valid", bus.p_valid, 1'b1);
        check("store rd p_rdata", bus.p_rdata, 32'hCAFE0001);

        // MAX_WAIT=1: strict alternation, pipeline first
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus1.p_req = 1'b1; bus1.p_addr = 12'h003;
            bus1.d_req = 1'b1; bus1.d_addr = 12'h005;
            #1;
            check($sformatf("alt%0d p_stall", i), bus1.p_stall, (i % 2) == 1);
            check($sformatf("alt%0d mem_addr", i), bus1.mem_addr, (i % 2) ? 12'h005 : 12'h003);
        end
        @(negedge clk);
        bus1.p_req = 1'b0; bus1.d_req = 1'b0;

        // reset lands while a forced debug response is pending
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 12'h001, '0, 1'b1, 12'h010);
        end
        @(negedge clk);
        #1;
        check("prerst p_stall", bus.p_stall, 1'b1);
        @(posedge clk);
        #1;
        in_RST = 1'b0;
        #1;
        check("midrst d_valid", bus.d_valid, 1'b0);
        check("midrst d_rdata", bus.d_rdata, 32'h0);
        check("midrst p_stall", bus.p_stall, 1'b0);
        check("midrst mem_en",  bus.mem_en,  1'b0);
        check("midrst p_rdata", bus.p_rdata, 32'h0);
        @(negedge clk);
        in_RST = 1'b1;
        #1;
        check("postrst p_stall",  bus.p_stall,  1'b0);
        check("postrst mem_addr", bus.mem_addr, 12'h001);
        check("postrst d_valid",  bus.d_valid,  1'b0);
        check("postrst p_valid",  bus.p_valid,  1'b0);

        // randomized run from a clean reset against the reference model
        @(negedge clk);
        in_RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        in_RST = 1'b1;
        denied = 0;
        m_pv = 1'b0; m_dv = 1'b0; m_prd = '0; m_drd = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
        begin
            logic pr, pw, ph, dr, forced, gp, gd, stall_prev;
            logic [AW-1:0] pa, da;
            logic [DW-1:0] pd;
            pr = 1'b0; pw = 1'b0; ph = 1'b0; pa = '0; pd = '0;
            stall_prev = 1'b0;
            for (int n = 0; n < 600; n++) begin
                @(negedge clk);
                if (!stall_prev) begin
                    pr = ($urandom_range(0, 99) < 60);
                    pw = 1'($urandom_range(0, 1));
                    ph = 1'($urandom_range(0, 1));
                    pa = AW'($urandom_range(0, 31));
                    pd = $urandom;
                end
                dr = ($urandom_range(0, 99) < 70);
                da = AW'($urandom_range(0, 63));
                drive(pr, pw, ph, pa, pd, dr, da);
                #1;
                forced = dr && (denied >= MW);
                gd = forced || (!pr && dr);
                gp = !forced && pr;
                check("rnd mem_en",   bus.mem_en,   gp || gd);
                check("rnd mem_we",   bus.mem_we,   gp && pw);
                check("rnd mem_half", bus.mem_half, gp && ph);
                if (gp || gd) begin
                    check("rnd mem_addr",  bus.mem_addr,  gp ? pa : da);
                    check("rnd mem_wdata", bus.mem_wdata, gp ? pd : 32'h0);
                end
                check("rnd p_stall", bus.p_stall, forced && pr);
                check("rnd p_valid", bus.p_valid, m_pv);
                check("rnd p_rdata", bus.p_rdata, m_prd);
                check("rnd d_valid", bus.d_valid, m_dv);
                check("rnd d_rdata", bus.d_rdata, m_drd);
                m_pv = gp && !pw;
                if (m_pv) m_prd = model_mem[pa[5:0]];
                if (gp && pw) model_mem[pa[5:0]] = pd;
                m_dv = gd;
                if (gd) m_drd = model_mem[da[5:0]];
                denied = gd ? 0 : (dr ? denied + 1 : 0);
                stall_prev = forced && pr;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the pipeline MEM/WB load/store path and the debug display read port.
- The debug port scans memory at a user-selected address for the 7-segment display.
- The pipeline has priority. A starvation counter guarantees the debug reader one slot every MAX_WAIT+1 contended cycles; in that slot the pipeline is stalled.
- Sits between the MEM/WB stage logic and the data memory. p_stall feeds the pipeline-register enable logic (EN).

Parameters:
AW, 12, memory word-address width
DW, 32, data width
MAX_WAIT, 8, contended cycles the debug port may be denied before a forced grant (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
in_RST  in  1  asynchronous active-low reset
p_req  in  1  pipeline access request, held while p_stall is 1
p_we  in  1  pipeline write (1) or read (0)
p_half  in  1  halfword access mode, passed to memory
p_addr  in  AW  pipeline address
p_wdata  in  DW  pipeline write data
p_rdata  out  DW  pipeline read data
p_valid  out  1  p_rdata valid pulse
p_stall  out  1  pipeline must hold; combinational
d_req  in  1  debug read request, level
d_addr  in  AW  debug address
d_rdata  out  DW  last debug read data, held
d_valid  out  1  d_rdata updated pulse
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write enable
mem_half  out  1  memory halfword mode
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, 1-cycle latency after mem_en with mem_we=0

Behaviour:
Reset:
- Reset is asynchronous, active-low on in_RST. Clock is clk.
- On reset: wait_cnt=0, state=PRI, resp=NONE.
- All outputs are 0, and d_rdata is 0.

Arbitration state (combinational from state and inputs):
- PRI (wait_cnt<MAX_WAIT):
  - p_req=1: grant the pipeline.
  - Else d_req=1: grant debug.
  - Else: idle, mem_en=0.
- FORCE (wait_cnt==MAX_WAIT):
  - d_req=1: grant debug, and p_stall=p_req.
  - d_req=0: behave as PRI.
- p_stall=1 only in the forced debug slot. It is never 1 when p_req=0.

Memory drive:
- Pipeline grant: mem_en=1, mem_we=p_we, mem_half=p_half, mem_addr=p_addr, mem_wdata=p_wdata.
- Debug grant: mem_en=1, mem_we=0, mem_half=0, mem_addr=d_addr, mem_wdata=0.

wait_cnt update (per clock):
- Debug granted: clear to 0.
- Else d_req=1 and pipeline granted: increment, saturating at MAX_WAIT.
- Else d_req=0: clear to 0.

Response register resp (NONE/P/D), set each clock from the grant:
- P for a pipeline read, D for a debug read, NONE otherwise. Writes produce no response.
- Cycle after a P read: p_valid=1 and p_rdata=mem_rdata. p_rdata holds until the next P response.
- Cycle after a D read: d_valid=1 and d_rdata=mem_rdata. d_rdata holds until the next D response.
- Read latency is 1 cycle for both ports.

Debug request timing:
- d_req may stay high continuously (display refresh). The port is then re-served every idle pipeline cycle.
- Under full contention it is served every MAX_WAIT+1 cycles.

Boundary cases:
- Simultaneous p_req and d_req with wait_cnt<MAX_WAIT: pipeline wins.
- MAX_WAIT=1 with full contention: strict alternation, pipeline first.
- d_req drops in FORCE: no stall, and the counter clears.
- Pipeline store during FORCE: the store is stalled and is not written until the following cycle.
- Reset asserted mid-operation: a pending valid is dropped (no p_valid/d_valid after reset), the counter clears, and p_stall deasserts immediately.
- p_req is sampled every cycle. The arbiter keeps no pending-request memory.

Test Plan:
1. Reset, then d_req=1, d_addr=0x010, p_req=0, memory[0x010]=0xDEADBEEF -> cycle 1: mem_addr=0x010, mem_en=1; cycle 2: d_valid=1, d_rdata=0xDEADBEEF; d_rdata still 0xDEADBEEF after d_req drops.
2. MAX_WAIT=8, p_req=1 (reads) and d_req=1 held continuously -> pipeline granted 8 cycles; cycle 9: debug granted and p_stall=1; cycle 10: d_valid=1, pipeline resumes; pattern repeats every 9 cycles.
3. Pipeline write p_we=1, p_addr=0x004, p_wdata=0x12345678, then read 0x004 -> mem_we=1 in cycle 1, p_valid=0; read in cycle 2 returns p_rdata=0x12345678 with p_valid in cycle 3.
4. wait_cnt reaches 8, then d_req drops before the forced slot -> p_stall stays 0, pipeline granted, wait_cnt=0.
5. Debug read granted, then in_RST=0 before the response cycle -> d_valid stays 0, d_rdata=0, all mem_* outputs=0 asynchronously.
6. MAX_WAIT=1 with full contention -> grants alternate P,D,P,D; p_stall=1 exactly on the D cycles.
